// File: rtl/rosetta_seq_controller_if.sv
// Instruction handshake and control-strobe bundle for rosetta_seq_controller.
// Perf counter signals exist only when ROSETTA_PERF_CNT_EN is defined.
interface rosetta_seq_controller_if #(
    parameter int unsigned K_W = 8,
    parameter int unsigned I_W = 8,
    parameter int unsigned J_W = 8,
    parameter int unsigned E_W = 10
);
    logic           inst_valid;
    logic           inst_ready;
    logic [1:0]     op;
    logic           acc;
    logic           last;
    logic [K_W-1:0] k_len;
    logic [I_W-1:0] i_len;
    logic [J_W-1:0] j_len;
    logic [E_W-1:0] e_len;

    logic           am_src0_ren;
    logic           am_src1_ren;
    logic           am_dst_ren;
    logic           am_dst_wen;
    logic           wm_ren;
    logic           bm_ren;
    logic [1:0]     oprnd1_sel;
    logic           oprnd2_sel;
    logic           mvma_first;
    logic           e_state;
    logic           done_wen;
    logic           all_done;

`ifdef ROSETTA_PERF_CNT_EN
    logic [31:0]    perf_busy;
    logic [15:0]    perf_inst;

    modport master (
        output inst_valid, op, acc, last, k_len, i_len, j_len, e_len,
        input  inst_ready, am_src0_ren, am_src1_ren, am_dst_ren, am_dst_wen,
               wm_ren, bm_ren, oprnd1_sel, oprnd2_sel, mvma_first, e_state,
               done_wen, all_done, perf_busy, perf_inst
    );

    modport slave (
        input  inst_valid, op, acc, last, k_len, i_len, j_len, e_len,
        output inst_ready, am_src0_ren, am_src1_ren, am_dst_ren, am_dst_wen,
               wm_ren, bm_ren, oprnd1_sel, oprnd2_sel, mvma_first, e_state,
               done_wen, all_done, perf_busy, perf_inst
    );
`else
    modport master (
        output inst_valid, op, acc, last, k_len, i_len, j_len, e_len,
        input  inst_ready, am_src0_ren, am_src1_ren, am_dst_ren, am_dst_wen,
               wm_ren, bm_ren, oprnd1_sel, oprnd2_sel, mvma_first, e_state,
               done_wen, all_done
    );

    modport slave (
        input  inst_valid, op, acc, last, k_len, i_len, j_len, e_len,
        output inst_ready, am_src0_ren, am_src1_ren, am_dst_ren, am_dst_wen,
               wm_ren, bm_ren, oprnd1_sel, oprnd2_sel, mvma_first, e_state,
               done_wen, all_done
    );
`endif
endinterface

// File: rtl/rosetta_seq_controller.sv
// Sequencing controller for ROSETTA_Core: self-timed k/i/j/e loops, post-op bubble, halt.
// Optional perf counters (perf_busy, perf_inst) are enabled by defining ROSETTA_PERF_CNT_EN.
module rosetta_seq_controller #(
    parameter int unsigned K_W    = 8,
    parameter int unsigned I_W    = 8,
    parameter int unsigned J_W    = 8,
    parameter int unsigned E_W    = 10,
    parameter int unsigned BUBBLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rosetta_seq_controller_if.slave bus
);

    localparam int unsigned B_W = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MVMA = 3'd1;
    localparam logic [2:0] S_EW   = 3'd2;
    localparam logic [2:0] S_BUB  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_MVMA = 2'd1;
    localparam logic [1:0] OP_EMAC = 2'd2;

    // Index of the final bubble cycle; a NOP still needs one cycle for its done strobe.
    localparam logic [B_W-1:0] BUB_LAST = (BUBBLE == 0) ? '0 : B_W'(BUBBLE - 1);

    logic [2:0]     state, state_nxt;
    logic [K_W-1:0] k, k_nxt;
    logic [I_W-1:0] i, i_nxt;
    logic [J_W-1:0] j, j_nxt;
    logic [E_W-1:0] e, e_nxt;
    logic [B_W-1:0] b, b_nxt;

    logic [1:0]     op_q, op_n;
    logic           acc_q, acc_n;
    logic           last_q, last_n;
    logic [K_W-1:0] k_len_q, k_len_n;
    logic [I_W-1:0] i_len_q, i_len_n;
    logic [J_W-1:0] j_len_q, j_len_n;
    logic [E_W-1:0] e_len_q, e_len_n;

    logic           accept;
    logic [2:0]     exit_state;
    logic [2:0]     done_state;
    logic           k_done, i_done, j_done;

    logic           ready_q, ready_d;
    logic           src0_q, src0_d;
    logic           src1_q, src1_d;
    logic           dst_r_q, dst_r_d;
    logic           dst_w_q, dst_w_d;
    logic           wm_q, wm_d;
    logic           bm_q, bm_d;
    logic [1:0]     sel1_q, sel1_d;
    logic           sel2_q, sel2_d;
    logic           first_q, first_d;
    logic           es_q, es_d;
    logic           done_q, done_d;
    logic           halt_q, halt_d;

    assign accept = bus.inst_valid & ready_q;

    // Instruction fields as they will be after this edge.
    assign op_n    = accept ? bus.op    : op_q;
    assign acc_n   = accept ? bus.acc   : acc_q;
    assign last_n  = accept ? bus.last  : last_q;
    assign k_len_n = accept ? bus.k_len : k_len_q;
    assign i_len_n = accept ? bus.i_len : i_len_q;
    assign j_len_n = accept ? bus.j_len : j_len_q;
    assign e_len_n = accept ? bus.e_len : e_len_q;

    assign k_done = (k == k_len_q);
    assign i_done = (i == i_len_q);
    assign j_done = (j == j_len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k       <= '0;
            i       <= '0;
            j       <= '0;
            e       <= '0;
            b       <= '0;
            op_q    <= '0;
            acc_q   <= 1'b0;
            last_q  <= 1'b0;
            k_len_q <= '0;
            i_len_q <= '0;
            j_len_q <= '0;
            e_len_q <= '0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            i       <= i_nxt;
            j       <= j_nxt;
            e       <= e_nxt;
            b       <= b_nxt;
            op_q    <= op_n;
            acc_q   <= acc_n;
            last_q  <= last_n;
            k_len_q <= k_len_n;
            i_len_q <= i_len_n;
            j_len_q <= j_len_n;
            e_len_q <= e_len_n;
        end
    end

    // Next state and loop counters; compare-before-increment keeps counters in range.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        i_nxt      = i;
        j_nxt      = j;
        e_nxt      = e;
        b_nxt      = b;
        exit_state = last_q ? S_HALT : S_IDLE;
        done_state = (BUBBLE == 0) ? exit_state : S_BUB;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    k_nxt = '0;
                    i_nxt = '0;
                    j_nxt = '0;
                    e_nxt = '0;
                    b_nxt = '0;
                    case (bus.op)
                        OP_NOP:  state_nxt = S_BUB;
                        OP_MVMA: state_nxt = S_MVMA;
                        default: state_nxt = S_EW;
                    endcase
                end
            end
            S_MVMA: begin
                if (k_done && i_done && j_done) begin
                    state_nxt = done_state;
                    k_nxt     = '0;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    b_nxt     = '0;
                end else if (!k_done) begin
                    k_nxt = k + K_W'(1);
                end else begin
                    k_nxt = '0;
                    if (!i_done) begin
                        i_nxt = i + I_W'(1);
                    end else begin
                        i_nxt = '0;
                        j_nxt = j + J_W'(1);
                    end
                end
            end
            S_EW: begin
                if (e == e_len_q) begin
                    state_nxt = done_state;
                    e_nxt     = '0;
                    b_nxt     = '0;
                end else begin
                    e_nxt = e + E_W'(1);
                end
            end
            S_BUB: begin
                if (b == BUB_LAST) begin
                    state_nxt = exit_state;
                    b_nxt     = '0;
                end else begin
                    b_nxt = b + B_W'(1);
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered so strobes align with that state.
    always_comb begin
        ready_d = 1'b0;
        src0_d  = 1'b0;
        src1_d  = 1'b0;
        dst_r_d = 1'b0;
        dst_w_d = 1'b0;
        wm_d    = 1'b0;
        bm_d    = 1'b0;
        sel1_d  = 2'b00;
        sel2_d  = 1'b0;
        first_d = 1'b0;
        es_d    = 1'b0;
        done_d  = 1'b0;
        halt_d  = 1'b0;

        case (state_nxt)
            S_IDLE: ready_d = 1'b1;
            S_MVMA: begin
                src0_d  = 1'b1;
                wm_d    = 1'b1;
                bm_d    = 1'b1;
                first_d = (k_nxt == '0);
                done_d  = (k_nxt == k_len_n) && (i_nxt == i_len_n) && (j_nxt == j_len_n);
            end
            S_EW: begin
                src0_d  = 1'b1;
                dst_w_d = 1'b1;
                if (op_n == OP_EMAC) begin
                    src1_d  = 1'b1;
                    dst_r_d = acc_n;
                    sel1_d  = 2'b01;
                    sel2_d  = 1'b0;
                end else begin
                    sel1_d  = 2'b10;
                    sel2_d  = 1'b1;
                end
                es_d   = (e_nxt != e_len_n);
                done_d = (e_nxt == e_len_n);
            end
            // Only a NOP enters the bubble straight from IDLE; its done strobe lands here.
            S_BUB:   done_d = (state == S_IDLE);
            S_HALT:  halt_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            src0_q  <= 1'b0;
            src1_q  <= 1'b0;
            dst_r_q <= 1'b0;
            dst_w_q <= 1'b0;
            wm_q    <= 1'b0;
            bm_q    <= 1'b0;
            sel1_q  <= 2'b00;
            sel2_q  <= 1'b0;
            first_q <= 1'b0;
            es_q    <= 1'b0;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            dst_r_q <= dst_r_d;
            dst_w_q <= dst_w_d;
            wm_q    <= wm_d;
            bm_q    <= bm_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            first_q <= first_d;
            es_q    <= es_d;
            done_q  <= done_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.inst_ready  = ready_q;
    assign bus.am_src0_ren = src0_q;
    assign bus.am_src1_ren = src1_q;
    assign bus.am_dst_ren  = dst_r_q;
    assign bus.am_dst_wen  = dst_w_q;
    assign bus.wm_ren      = wm_q;
    assign bus.bm_ren      = bm_q;
    assign bus.oprnd1_sel  = sel1_q;
    assign bus.oprnd2_sel  = sel2_q;
    assign bus.mvma_first  = first_q;
    assign bus.e_state     = es_q;
    assign bus.done_wen    = done_q;
    assign bus.all_done    = halt_q;

`ifdef ROSETTA_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_inst_q;

    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q <= '0;
            perf_inst_q <= '0;
        end else begin
            if ((state != S_IDLE) && (state != S_HALT) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'(1);
            end
            if (done_q && (perf_inst_q != '1)) begin
                perf_inst_q <= perf_inst_q + 16'(1);
            end
        end
    end

    assign bus.perf_busy = perf_busy_q;
    assign bus.perf_inst = perf_inst_q;
`endif

endmodule

// File: tb/tb_rosetta_seq_controller.sv
// Self-checking bench for rosetta_seq_controller: per-cycle model compare plus directed literal checks.
module tb_rosetta_seq_controller;

    localparam int unsigned TK = 2;
    localparam int unsigned TI = 2;
    localparam int unsigned TJ = 2;
    localparam int unsigned TE = 10;
    localparam int          TB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rosetta_seq_controller_if #(.K_W(TK), .I_W(TI), .J_W(TJ), .E_W(TE)) bus ();

    rosetta_seq_controller #(
        .K_W(TK), .I_W(TI), .J_W(TJ), .E_W(TE), .BUBBLE(TB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       s0, s1, dr, dw, wm, bm;
        logic [1:0] o1;
        logic       o2, first, es, done, ready, alld;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    bit   halt_after = 1'b0;
    bit   fresh = 1'b1;
    vec_t rec[128];

    function automatic vec_t sample();
        vec_t v;
        v.s0    = bus.am_src0_ren;
        v.s1    = bus.am_src1_ren;
        v.dr    = bus.am_dst_ren;
        v.dw    = bus.am_dst_wen;
        v.wm    = bus.wm_ren;
        v.bm    = bus.bm_ren;
        v.o1    = bus.oprnd1_sel;
        v.o2    = bus.oprnd2_sel;
        v.first = bus.mvma_first;
        v.es    = bus.e_state;
        v.done  = bus.done_wen;
        v.ready = bus.inst_ready;
        v.alld  = bus.all_done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: the whole per-cycle output sequence of one instruction, from the loop rules.
    function automatic void push_inst(input int op, input int acc, input int last,
                                      input int kl, input int il, input int jl, input int el);
        vec_t v;
        if (op == 0) begin
            v = '0;
            v.done = 1'b1;
            exp_q.push_back(v);
            for (int c = 1; c < TB; c++) exp_q.push_back(vec_t'(0));
        end else begin
            if (op == 1) begin
                for (int jj = 0; jj <= jl; jj++)
                    for (int ii = 0; ii <= il; ii++)
                        for (int kk = 0; kk <= kl; kk++) begin
                            v = '0;
                            v.s0 = 1'b1; v.wm = 1'b1; v.bm = 1'b1;
                            v.first = (kk == 0);
                            v.done  = (kk == kl) && (ii == il) && (jj == jl);
                            exp_q.push_back(v);
                        end
            end else begin
                for (int ee = 0; ee <= el; ee++) begin
                    v = '0;
                    v.s0 = 1'b1;
                    v.dw = 1'b1;
                    if (op == 2) begin
                        v.s1 = 1'b1;
                        v.dr = (acc != 0);
                        v.o1 = 2'b01;
                    end else begin
                        v.o1 = 2'b10;
                        v.o2 = 1'b1;
                    end
                    v.es   = (ee != el);
                    v.done = (ee == el);
                    exp_q.push_back(v);
                end
            end
            for (int c = 0; c < TB; c++) exp_q.push_back(vec_t'(0));
        end
        halt_after = (last != 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                halt_after = 1'b0;
                fresh = 1'b1;
            end else if (fresh) begin
                fresh = 1'b0;
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end else if (!halt_after && bus.inst_valid) begin
                push_inst(int'(bus.op), int'(bus.acc), int'(bus.last), int'(bus.k_len),
                          int'(bus.i_len), int'(bus.j_len), int'(bus.e_len));
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || fresh) begin
                e = '0;
            end else if (exp_q.size() != 0) begin
                e = exp_q[0];
            end else begin
                e = '0;
                if (halt_after) e.alld = 1'b1;
                else            e.ready = 1'b1;
            end
            check("cycle", 32'(sample()), 32'(e));
        end
    end

    task automatic issue(input int op, input int acc, input int last, input int kl,
                         input int il, input int jl, input int el, input bit hold);
        int n = 0;
        while (bus.inst_ready !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", 32'(bus.inst_ready), 32'd1);
        bus.inst_valid = 1'b1;
        bus.op    = 2'(op);
        bus.acc   = 1'(acc);
        bus.last  = 1'(last);
        bus.k_len = TK'(kl);
        bus.i_len = TI'(il);
        bus.j_len = TJ'(jl);
        bus.e_len = TE'(el);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.inst_valid = 1'b0;
            bus.op    = 2'($urandom);
            bus.acc   = 1'($urandom);
            bus.last  = 1'($urandom);
            bus.k_len = TK'($urandom);
            bus.i_len = TI'($urandom);
            bus.j_len = TJ'($urandom);
            bus.e_len = TE'($urandom);
        end
    endtask

    task automatic record(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rec[c] = sample();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt_a, cnt_b, idx;
        logic [31:0] mask_a, mask_b;

        bus.inst_valid = 1'b0;
        bus.op = '0; bus.acc = 1'b0; bus.last = 1'b0;
        bus.k_len = '0; bus.i_len = '0; bus.j_len = '0; bus.e_len = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 32'(sample()), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_reset", 32'(bus.inst_ready), 32'd1);

        // MVMA k_len=2 i_len=1 j_len=0
        issue(1, 0, 0, 2, 1, 0, 0, 1'b0);
        record(12);
        cnt_a = 0; mask_a = '0; mask_b = '0; idx = -1;
        for (int c = 0; c < 12; c++) begin
            cnt_a += int'(rec[c].wm);
            mask_a[c] = rec[c].first;
            mask_b[c] = rec[c].done;
            if (idx < 0 && rec[c].ready) idx = c;
        end
        check("mvma_enable_cycles", 32'(cnt_a), 32'd6);
        check("mvma_first_mask", mask_a, 32'h009);
        check("mvma_done_mask", mask_b, 32'h020);
        check("mvma_ready_return", 32'(idx), 32'd9);

        // EMAC acc=1 / acc=0, e_len=4
        for (int a = 1; a >= 0; a--) begin
            issue(2, a, 0, 0, 0, 0, 4, 1'b0);
            record(6);
            cnt_a = 0; cnt_b = 0; mask_b = '0;
            for (int c = 0; c < 6; c++) begin
                cnt_a += int'(rec[c].dr);
                cnt_b += int'(rec[c].es);
                mask_b[c] = rec[c].done;
            end
            check("emac_dst_ren_cycles", 32'(cnt_a), (a == 1) ? 32'd5 : 32'd0);
            check("emac_e_state_cycles", 32'(cnt_b), 32'd4);
            check("emac_done_mask", mask_b, 32'h010);
        end

        // ENOF e_len=0
        issue(3, 0, 0, 0, 0, 0, 0, 1'b0);
        record(1);
        check("enof_oprnd1_sel", 32'(rec[0].o1), 32'd2);
        check("enof_oprnd2_sel", 32'(rec[0].o2), 32'd1);
        check("enof_done", 32'(rec[0].done), 32'd1);
        check("enof_e_state", 32'(rec[0].es), 32'd0);

        // MVMA all lens at max for 2-bit counters
        issue(1, 0, 0, 3, 3, 3, 0, 1'b0);
        record(70);
        cnt_a = 0; cnt_b = 0; idx = -1;
        for (int c = 0; c < 70; c++) begin
            cnt_a += int'(rec[c].wm);
            cnt_b += int'(rec[c].done);
            if (rec[c].done) idx = c;
        end
        check("max_enable_cycles", 32'(cnt_a), 32'd64);
        check("max_done_count", 32'(cnt_b), 32'd1);
        check("max_done_index", 32'(idx), 32'd63);

        // Reset during MVMA step 3
        issue(1, 0, 0, 3, 3, 3, 0, 1'b0);
        record(3);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(sample()), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_abort", 32'(bus.inst_ready), 32'd1);
        record(5);
        cnt_a = 0;
        for (int c = 0; c < 5; c++) cnt_a += int'(rec[c].done);
        check("abort_no_done", 32'(cnt_a), 32'd0);

        // NOP, not last
        issue(0, 0, 0, 0, 0, 0, 0, 1'b0);
        record(4);
        mask_b = '0; idx = -1;
        for (int c = 0; c < 4; c++) begin
            mask_b[c] = rec[c].done;
            if (idx < 0 && rec[c].ready) idx = c;
        end
        check("nop_done_mask", mask_b, 32'h001);
        check("nop_ready_return", 32'(idx), 32'd3);

        // NOP last=1 with inst_valid held high afterwards
        issue(0, 0, 1, 0, 0, 0, 0, 1'b1);
        record(105);
        cnt_a = 0; cnt_b = 0; idx = -1; mask_a = '0;
        for (int c = 0; c < 105; c++) begin
            cnt_a += int'(rec[c].alld);
            cnt_b += int'(rec[c].ready);
            mask_a += 32'(rec[c].done);
            if (idx < 0 && rec[c].alld) idx = c;
        end
        check("halt_done_count", mask_a, 32'd1);
        check("halt_first_index", 32'(idx), 32'd3);
        check("halt_all_done_cycles", 32'(cnt_a), 32'd102);
        check("halt_ready_cycles", 32'(cnt_b), 32'd0);

        bus.inst_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rosetta_seq_controller.md
Name: rosetta_seq_controller

Overview:
- Sequential, parametrised controller for ROSETTA_Core.
- Generates loop-end events internally with its own k/i/j/e counters instead of taking k_end/i_end/j_end/e_end from the datapath.
- Accepts one decoded instruction per valid/ready handshake and drives the memory-enable, operand-select and done strobes for NOP, MVMA, EMAC and ENOF.
- Enforces a parametrised post-instruction pipeline bubble, and holds an all-done halt after the last instruction.

Parameters:
- K_W, 8, width of k_len and of the k counter (innermost MVMA loop, reduction depth).
- I_W, 8, width of i_len and of the i counter (MVMA row tiles).
- J_W, 8, width of j_len and of the j counter (MVMA column tiles, outermost).
- E_W, 10, width of e_len and of the e counter (element-wise length).
- BUBBLE, 3, pipeline-drain cycles after each instruction; valid range 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction fields are valid
- inst_ready  out  1  controller can accept an instruction
- op  in  2  opcode: 0 NOP, 1 MVMA, 2 EMAC, 3 ENOF
- acc  in  1  EMAC accumulate (adds am_dst read)
- last  in  1  last instruction of the program
- k_len  in  K_W  k trip count minus 1
- i_len  in  I_W  i trip count minus 1
- j_len  in  J_W  j trip count minus 1
- e_len  in  E_W  element count minus 1
- am_src0_ren, am_src1_ren, am_dst_ren, am_dst_wen, wm_ren, bm_ren  out  1 each  memory enables
- oprnd1_sel  out  2  operand-1 mux select
- oprnd2_sel  out  1  operand-2 mux select
- mvma_first  out  1  first k step of a tile (clear accumulator)
- e_state  out  1  element-wise op in progress
- done_wen  out  1  one-cycle instruction-complete strobe
- all_done  out  1  program halted

Behaviour:
- Reset value: every output is 0 except inst_ready. inst_ready is 1 from the first clock after rst_n rises. Counters reset to 0. State resets to IDLE.
- States: IDLE, MVMA, EW, BUBBLE, HALT. inst_ready = (state == IDLE).
- Fields are captured on the accept edge (inst_valid & inst_ready). Input changes after that edge have no effect until the next accept.
- IDLE + accept:
  - op 0 (NOP): go to BUBBLE; done_wen pulses on the entry cycle.
  - op 1: go to MVMA.
  - op 2 or 3: go to EW.
  - Counters clear on accept.
- MVMA, one step per cycle:
  - Outputs each cycle: am_src0_ren = wm_ren = bm_ren = 1.
  - mvma_first = 1 when k == 0.
  - Loop order: k increments; on k == k_len, k wraps to 0 and i increments; on i == i_len, i wraps and j increments.
  - The step where k, i and j all equal their len values is the last step. That cycle also asserts done_wen; next state is BUBBLE.
  - Cycle count = (k_len+1)(i_len+1)(j_len+1).
- EW, one element per cycle for e_len+1 cycles:
  - EMAC: am_src0_ren = am_src1_ren = 1, am_dst_ren = acc, am_dst_wen = 1, oprnd1_sel = 2'b01, oprnd2_sel = 0.
  - ENOF: am_src0_ren = am_dst_wen = 1, oprnd1_sel = 2'b10, oprnd2_sel = 1.
  - e_state = 1 on all cycles except the final one (e == e_len). The final cycle asserts done_wen; next state is BUBBLE.
- BUBBLE:
  - Counts BUBBLE cycles with all enables 0.
  - Then goes to HALT if the captured last = 1, else IDLE.
  - With BUBBLE = 0, BUBBLE is skipped: the state goes straight to HALT/IDLE after the done cycle.
- HALT: all_done = 1, inst_ready = 0, all enables 0. Exited only by reset.
- Output timing: control outputs are Moore, decoded from registered state and counters. The first enable is asserted in the cycle after accept.
- inst_valid while not ready is ignored; it is not queued.
- All len = 0: MVMA and EW each last exactly 1 cycle, with done_wen in that cycle.
- Max len: counters are exactly len width and never overflow, because comparison happens before increment.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No done_wen is produced for the aborted instruction.

Optional Feature:
- Macro: ROSETTA_PERF_CNT_EN.
- When defined, adds outputs perf_busy (32) and perf_inst (16).
  - perf_busy counts cycles with state ≠ IDLE/HALT.
  - perf_inst counts done_wen pulses.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- MVMA, k_len=2, i_len=1, j_len=0, BUBBLE=3 → 6 enable cycles; mvma_first high on cycles 1 and 4; done_wen on cycle 6; inst_ready returns 4 cycles later.
- EMAC acc=1, e_len=4 → am_dst_ren=1 for 5 cycles; e_state high 4 cycles; done_wen on 5th. Repeat with acc=0 → am_dst_ren stays 0.
- ENOF e_len=0 → single cycle with oprnd1_sel=2'b10, oprnd2_sel=1, done_wen=1, e_state=0.
- NOP last=1, then inst_valid held high → done_wen pulse; BUBBLE cycles; all_done=1; inst_ready stays 0 for 100 cycles.
- MVMA with all lens at max (K_W=I_W=J_W=2) → exactly 64 cycles; counters wrap cleanly; a single done_wen.
- rst_n low at MVMA step 3 → all outputs 0 asynchronously; after release inst_ready=1 and no done_wen.
